// File: rtl/pic_seq_pkg.sv
// rtl/pic_seq_pkg.sv - shared types, defaults and width helper for the sequential interrupt controller
package pic_seq_pkg;

    localparam int DEFAULT_N_CHAN = 9;
    localparam int DEFAULT_N_LVL  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SERVICE = 2'd2
    } pic_state_t;

    // Index width for n items, never narrower than one bit so a single-entry vector still has an index port
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pic_prio_enc.sv
// rtl/pic_prio_enc.sv - lowest-index-wins priority encoder
module pic_prio_enc
    import pic_seq_pkg::*;
#(
    parameter int W  = DEFAULT_N_CHAN,
    parameter int IW = clog2_min1(W)
) (
    input  logic [W-1:0]  i_req,
    output logic          o_any,
    output logic [IW-1:0] o_idx
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        o_any = |i_req;
        o_idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = IW'(i);
        end
    end

endmodule

// File: rtl/pic_seq_ctrl.sv
// rtl/pic_seq_ctrl.sv - clocked level/channel priority interrupt controller with ack and EOI handshake
module pic_seq_ctrl
    import pic_seq_pkg::*;
#(
    parameter int N_CHAN    = DEFAULT_N_CHAN,
    parameter int N_LVL     = DEFAULT_N_LVL,
    parameter int EDGE_MODE = 0,
    parameter int CW        = clog2_min1(N_CHAN),
    parameter int LW        = clog2_min1(N_LVL)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CHAN-1:0]       chan_en,
    input  logic [N_LVL*N_CHAN-1:0] req,
    output logic [N_LVL-1:0]        lvl_pend,
    output logic                    irq_valid,
    output logic [LW-1:0]           irq_lvl,
    output logic [CW-1:0]           irq_chan,
    input  logic                    irq_ack,
    output logic                    in_service,
    input  logic                    eoi,
    output logic                    spurious_eoi,
    output logic                    lost_edge
);

    localparam int NB = N_LVL * N_CHAN;

    pic_state_t        r_state;
    pic_state_t        w_state_nxt;
    logic [NB-1:0]     r_pend;
    logic [NB-1:0]     r_req_q;
    logic [NB-1:0]     w_en_full;
    logic [NB-1:0]     w_set;
    logic [NB-1:0]     w_clr;
    logic [NB-1:0]     w_pend_nxt;
    logic [N_LVL-1:0]  r_lvl_pend;
    logic [N_LVL-1:0]  w_lvl_any;
    logic [LW-1:0]     r_irq_lvl;
    logic [LW-1:0]     w_win_lvl;
    logic [CW-1:0]     r_irq_chan;
    logic [CW-1:0]     w_win_chan;
    logic [CW-1:0]     w_chan_idx [2**LW];
    logic              w_any;
    logic              w_ack;
    logic              r_spur;
    logic              r_lost;

    // Channel enables apply identically at every level; level-major layout makes this a plain replication
    assign w_en_full = {N_LVL{chan_en}};
    assign w_ack     = (r_state == PRESENT) && irq_ack;
    assign w_set     = req & ~r_req_q & w_en_full;

    // Edge mode keeps a bit until its own ack; a fresh rise in the ack cycle wins over the clear
    assign w_pend_nxt = (EDGE_MODE != 0) ? (((r_pend & ~w_clr) & w_en_full) | w_set)
                                         : (req & w_en_full);

    generate
        for (genvar g_l = 0; g_l < 2**LW; g_l++) begin : g_lvl
            if (g_l < N_LVL) begin : g_enc
                pic_prio_enc #(.W(N_CHAN), .IW(CW)) u_chan_enc (
                    .i_req (r_pend[g_l*N_CHAN +: N_CHAN]),
                    .o_any (w_lvl_any[g_l]),
                    .o_idx (w_chan_idx[g_l])
                );
            end else begin : g_pad
                assign w_chan_idx[g_l] = '0;
            end
        end
    endgenerate

    pic_prio_enc #(.W(N_LVL), .IW(LW)) u_lvl_enc (
        .i_req (w_lvl_any),
        .o_any (w_any),
        .o_idx (w_win_lvl)
    );

    assign w_win_chan = w_chan_idx[w_win_lvl];

    // One-hot clear for the acknowledged source, decoded from the frozen presentation indices
    always_comb begin
        w_clr = '0;
        for (int l = 0; l < N_LVL; l++) begin
            for (int c = 0; c < N_CHAN; c++) begin
                w_clr[l*N_CHAN + c] = w_ack && (r_irq_lvl == LW'(l)) && (r_irq_chan == CW'(c));
            end
        end
    end

    // Capture pending bits, the edge-detect history, per-level summary and the error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= '0;
            r_req_q    <= '0;
            r_lvl_pend <= '0;
            r_spur     <= 1'b0;
            r_lost     <= 1'b0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_req_q    <= req;
            r_lvl_pend <= w_lvl_any;
            r_spur     <= eoi && (r_state != SERVICE);
            r_lost     <= (EDGE_MODE != 0) && (|(w_set & r_pend & ~w_clr));
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: present any pending winner, wait for ack, then hold until EOI
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any)   w_state_nxt = PRESENT;
            PRESENT: if (irq_ack) w_state_nxt = SERVICE;
            SERVICE: if (eoi)     w_state_nxt = IDLE;
            default:              w_state_nxt = IDLE;
        endcase
    end

    // Latch the winner only when leaving IDLE so presentation and service see a frozen source
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_lvl  <= '0;
            r_irq_chan <= '0;
        end else if ((r_state == IDLE) && w_any) begin
            r_irq_lvl  <= w_win_lvl;
            r_irq_chan <= w_win_chan;
        end
    end

    assign lvl_pend     = r_lvl_pend;
    assign irq_valid    = (r_state == PRESENT);
    assign in_service   = (r_state == SERVICE);
    assign irq_lvl      = r_irq_lvl;
    assign irq_chan     = r_irq_chan;
    assign spurious_eoi = r_spur;
    assign lost_edge    = r_lost;

endmodule

// File: tb/tb_pic_seq_ctrl.sv
// tb/tb_pic_seq_ctrl.sv - testbench for pic_seq_ctrl, level-mode and edge-mode instances
module tb_pic_seq_ctrl;

    localparam int NC = 9;
    localparam int NL = 3;
    localparam int NB = NC * NL;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0][NB-1:0]   req;
    logic [1:0][NC-1:0]   en;
    logic [1:0]           ack, eoi;
    logic [1:0][NL-1:0]   lvl_pend;
    logic [1:0]           valid, in_svc, spur, lost;
    logic [1:0][1:0]      lvl;
    logic [1:0][3:0]      chan;

    logic [1:0][NB-1:0]   m_pend, m_reqq;
    logic [1:0][NL-1:0]   m_lp;
    int                   m_st [2];
    int                   m_lvl [2];
    int                   m_chan [2];
    logic                 m_spur [2];
    logic                 m_lost [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pic_seq_ctrl #(.N_CHAN(NC), .N_LVL(NL), .EDGE_MODE(0)) u_dut_lvl (
        .clk(clk), .rst_n(rst_n), .chan_en(en[0]), .req(req[0]), .lvl_pend(lvl_pend[0]),
        .irq_valid(valid[0]), .irq_lvl(lvl[0]), .irq_chan(chan[0]), .irq_ack(ack[0]),
        .in_service(in_svc[0]), .eoi(eoi[0]), .spurious_eoi(spur[0]), .lost_edge(lost[0])
    );

    pic_seq_ctrl #(.N_CHAN(NC), .N_LVL(NL), .EDGE_MODE(1)) u_dut_edge (
        .clk(clk), .rst_n(rst_n), .chan_en(en[1]), .req(req[1]), .lvl_pend(lvl_pend[1]),
        .irq_valid(valid[1]), .irq_lvl(lvl[1]), .irq_chan(chan[1]), .irq_ack(ack[1]),
        .in_service(in_svc[1]), .eoi(eoi[1]), .spurious_eoi(spur[1]), .lost_edge(lost[1])
    );

    function automatic logic [NB-1:0] bm(input int l, input int c);
        logic [NB-1:0] v;
        v = '0;
        v[l*NC + c] = 1'b1;
        return v;
    endfunction

    // One clock: reference model consumes the inputs seen at the edge, then outputs settle
    task automatic tick();
        logic [NB-1:0] rise, nxt;
        int w, cl;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_pend[k] = '0; m_reqq[k] = '0; m_lp[k] = '0; m_st[k] = 0;
                m_lvl[k] = 0; m_chan[k] = 0; m_spur[k] = 1'b0; m_lost[k] = 1'b0;
            end else begin
                w = -1;
                for (int i = NB - 1; i >= 0; i--) if (m_pend[k][i]) w = i;
                cl = ((m_st[k] == 1) && ack[k]) ? (m_lvl[k] * NC + m_chan[k]) : -1;
                rise = req[k] & ~m_reqq[k];
                m_lost[k] = 1'b0;
                for (int i = 0; i < NB; i++) begin
                    if (!en[k][i % NC])  nxt[i] = 1'b0;
                    else if (k == 0)     nxt[i] = req[k][i];
                    else begin
                        nxt[i] = rise[i] || (m_pend[k][i] && (i != cl));
                        if (rise[i] && m_pend[k][i] && (i != cl)) m_lost[k] = 1'b1;
                    end
                end
                for (int l = 0; l < NL; l++) m_lp[k][l] = |m_pend[k][l*NC +: NC];
                m_spur[k] = eoi[k] && (m_st[k] != 2);
                case (m_st[k])
                    0: if (w >= 0) begin m_st[k] = 1; m_lvl[k] = w / NC; m_chan[k] = w % NC; end
                    1: if (ack[k]) m_st[k] = 2;
                    default: if (eoi[k]) m_st[k] = 0;
                endcase
                m_pend[k] = nxt;
                m_reqq[k] = req[k];
            end
        end
        #1;
    endtask

    task automatic drain(input int k);
        req[k] = '0;
        for (int i = 0; i < 8; i++) begin
            ack[k] = valid[k];
            eoi[k] = in_svc[k];
            tick();
        end
        ack[k] = 1'b0;
        eoi[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ack = '0; eoi = '0;
        for (int k = 0; k < 2; k++) begin
            req[k] = {$urandom, $urandom};
            en[k]  = NC'($urandom);
        end
        for (int i = 0; i < 3; i++) tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({lvl_pend[k], valid[k], lvl[k], chan[k], in_svc[k], spur[k], lost[k]} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got pend=%b v=%b lvl=%0d ch=%0d svc=%b spur=%b lost=%b, expected all 0",
                         k, lvl_pend[k], valid[k], lvl[k], chan[k], in_svc[k], spur[k], lost[k]);
            end
        end
        req = '0;
        en  = {2{{NC{1'b1}}}};
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (valid !== 2'b00) begin
                n_fail++;
                $display("FAIL idle_after_reset cycle %0d: got valid=%b, expected 00", i, valid);
            end
        end
    endtask

    task automatic test_priority();
        req[0] = bm(1, 4) | bm(0, 7);
        tick();
        n_checks++;
        if (valid[0] !== 1'b0) begin
            n_fail++; $display("FAIL prio_latency1: got valid=%b, expected 0", valid[0]);
        end
        tick();
        n_checks++;
        if (valid[0] !== 1'b1 || lvl[0] !== 2'd0 || chan[0] !== 4'd7) begin
            n_fail++; $display("FAIL prio_first: got v=%b lvl=%0d ch=%0d, expected 1/0/7", valid[0], lvl[0], chan[0]);
        end
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        req[0] = bm(1, 4);
        n_checks++;
        if (in_svc[0] !== 1'b1 || valid[0] !== 1'b0) begin
            n_fail++; $display("FAIL prio_ack: got svc=%b v=%b, expected 1/0", in_svc[0], valid[0]);
        end
        eoi[0] = 1'b1; tick(); eoi[0] = 1'b0;
        n_checks++;
        if (in_svc[0] !== 1'b0 || valid[0] !== 1'b0) begin
            n_fail++; $display("FAIL prio_idle_gap: got svc=%b v=%b, expected 0/0", in_svc[0], valid[0]);
        end
        tick();
        n_checks++;
        if (valid[0] !== 1'b1 || lvl[0] !== 2'd1 || chan[0] !== 4'd4) begin
            n_fail++; $display("FAIL prio_second: got v=%b lvl=%0d ch=%0d, expected 1/1/4", valid[0], lvl[0], chan[0]);
        end
        drain(0);
    endtask

    task automatic test_stability();
        req[0] = bm(2, 3);
        tick(); tick();
        req[0] = bm(2, 3) | bm(0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (valid[0] !== 1'b1 || lvl[0] !== 2'd2 || chan[0] !== 4'd3) begin
                n_fail++; $display("FAIL stable_frozen %0d: got v=%b lvl=%0d ch=%0d, expected 1/2/3", i, valid[0], lvl[0], chan[0]);
            end
        end
        n_checks++;
        if (lvl_pend[0] !== 3'b101) begin
            n_fail++; $display("FAIL stable_lvl_pend: got %b, expected 101", lvl_pend[0]);
        end
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        req[0] = bm(0, 0);
        eoi[0] = 1'b1; tick(); eoi[0] = 1'b0;
        tick();
        n_checks++;
        if (valid[0] !== 1'b1 || lvl[0] !== 2'd0 || chan[0] !== 4'd0) begin
            n_fail++; $display("FAIL stable_after_eoi: got v=%b lvl=%0d ch=%0d, expected 1/0/0", valid[0], lvl[0], chan[0]);
        end
        drain(0);
    endtask

    task automatic test_edge_collision();
        int cnt;
        cnt = 0;
        req[1] = bm(0, 2); tick(); cnt += int'(lost[1]);
        req[1] = '0;       tick(); cnt += int'(lost[1]);
        req[1] = bm(0, 2); tick(); cnt += int'(lost[1]);
        req[1] = '0;       tick(); cnt += int'(lost[1]);
        n_checks++;
        if (cnt != 1) begin
            n_fail++; $display("FAIL edge_lost_count: got %0d pulses, expected 1", cnt);
        end
        n_checks++;
        if (valid[1] !== 1'b1 || lvl[1] !== 2'd0 || chan[1] !== 4'd2) begin
            n_fail++; $display("FAIL edge_present: got v=%b lvl=%0d ch=%0d, expected 1/0/2", valid[1], lvl[1], chan[1]);
        end
        req[1] = bm(0, 2); ack[1] = 1'b1; tick();
        req[1] = '0;       ack[1] = 1'b0; tick();
        n_checks++;
        if (in_svc[1] !== 1'b1 || lvl_pend[1] !== 3'b001) begin
            n_fail++; $display("FAIL edge_collision_pend: got svc=%b lvl_pend=%b, expected 1/001", in_svc[1], lvl_pend[1]);
        end
        eoi[1] = 1'b1; tick(); eoi[1] = 1'b0;
        tick();
        n_checks++;
        if (valid[1] !== 1'b1 || lvl[1] !== 2'd0 || chan[1] !== 4'd2) begin
            n_fail++; $display("FAIL edge_represent: got v=%b lvl=%0d ch=%0d, expected 1/0/2", valid[1], lvl[1], chan[1]);
        end
        ack[1] = 1'b1; tick(); ack[1] = 1'b0;
        eoi[1] = 1'b1; tick(); eoi[1] = 1'b0;
        tick(); tick();
        n_checks++;
        if (valid[1] !== 1'b0 || lvl_pend[1] !== 3'b000) begin
            n_fail++; $display("FAIL edge_cleared: got v=%b lvl_pend=%b, expected 0/000", valid[1], lvl_pend[1]);
        end
        drain(1);
    endtask

    task automatic test_masking();
        en[0][5] = 1'b0;
        req[0] = bm(0, 5) | bm(1, 5) | bm(2, 5);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (valid[0] !== 1'b0 || lvl_pend[0] !== 3'b000) begin
                n_fail++; $display("FAIL mask_hold %0d: got v=%b lvl_pend=%b, expected 0/000", i, valid[0], lvl_pend[0]);
            end
        end
        en[0][5] = 1'b1;
        tick();
        n_checks++;
        if (valid[0] !== 1'b0) begin
            n_fail++; $display("FAIL mask_release_latency: got v=%b, expected 0", valid[0]);
        end
        tick();
        n_checks++;
        if (valid[0] !== 1'b1 || lvl[0] !== 2'd0 || chan[0] !== 4'd5) begin
            n_fail++; $display("FAIL mask_release: got v=%b lvl=%0d ch=%0d, expected 1/0/5", valid[0], lvl[0], chan[0]);
        end
        drain(0);
    endtask

    task automatic test_errors();
        eoi[0] = 1'b1; tick(); eoi[0] = 1'b0;
        n_checks++;
        if (spur[0] !== 1'b1) begin
            n_fail++; $display("FAIL spurious_pulse: got %b, expected 1", spur[0]);
        end
        tick();
        n_checks++;
        if (spur[0] !== 1'b0) begin
            n_fail++; $display("FAIL spurious_width: got %b, expected 0", spur[0]);
        end
        req[0] = bm(1, 1);
        tick(); tick();
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        n_checks++;
        if (in_svc[0] !== 1'b1) begin
            n_fail++; $display("FAIL async_pre_service: got svc=%b, expected 1", in_svc[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_svc[0] !== 1'b0 || valid[0] !== 1'b0 || lvl[0] !== 2'd0 || chan[0] !== 4'd0) begin
            n_fail++; $display("FAIL async_reset: got svc=%b v=%b lvl=%0d ch=%0d, expected all 0", in_svc[0], valid[0], lvl[0], chan[0]);
        end
        req = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < NB; i++) req[k][i] = ($urandom_range(0, 5) == 0);
                for (int c = 0; c < NC; c++) en[k][c] = ($urandom_range(0, 9) != 0);
                ack[k] = $urandom_range(0, 1) == 1;
                eoi[k] = $urandom_range(0, 2) == 0;
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (valid[k] !== (m_st[k] == 1) || in_svc[k] !== (m_st[k] == 2)) begin
                    n_fail++; $display("FAIL rand_state[%0d] n=%0d: got v=%b svc=%b, expected phase %0d", k, n, valid[k], in_svc[k], m_st[k]);
                end
                n_checks++;
                if (lvl[k] !== 2'(m_lvl[k]) || chan[k] !== 4'(m_chan[k])) begin
                    n_fail++; $display("FAIL rand_index[%0d] n=%0d: got lvl=%0d ch=%0d, expected %0d/%0d", k, n, lvl[k], chan[k], m_lvl[k], m_chan[k]);
                end
                n_checks++;
                if (lvl_pend[k] !== m_lp[k]) begin
                    n_fail++; $display("FAIL rand_lvl_pend[%0d] n=%0d: got %b, expected %b", k, n, lvl_pend[k], m_lp[k]);
                end
                n_checks++;
                if (spur[k] !== m_spur[k] || lost[k] !== m_lost[k]) begin
                    n_fail++; $display("FAIL rand_pulses[%0d] n=%0d: got spur=%b lost=%b, expected %b/%b", k, n, spur[k], lost[k], m_spur[k], m_lost[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_stability();
        test_edge_collision();
        test_masking();
        test_errors();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pic_seq_ctrl.md
Name: pic_seq_ctrl

Overview:
- Clocked, parametrised interrupt controller for N_LVL priority groups × N_CHAN channels (default 3×9 = 27 sources).
- Captures requests into pending registers, arbitrates level first (level 0 highest), then channel (index 0 highest).
- Presents the winner on a valid/ack handshake and holds it in-service until end-of-interrupt (EOI).
- Sits between peripheral request lines and the CPU interrupt interface; replaces the purely combinational 27-channel controller.

Parameters:
- N_CHAN, 9, channels per priority level (2..32).
- N_LVL, 3, priority levels (1..8); level 0 is highest.
- EDGE_MODE, 0, 0 = level-sensitive capture, 1 = rising-edge sticky capture.
- CW, $clog2(N_CHAN), derived channel index width; not overridden.
- LW, max(1,$clog2(N_LVL)), derived level index width; not overridden.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- chan_en  in  N_CHAN  per-channel enable; a disabled channel never becomes pending.
- req  in  N_LVL*N_CHAN  requests, level-major: bit l*N_CHAN+c = level l, channel c.
- lvl_pend  out  N_LVL  registered OR of pending bits per level.
- irq_valid  out  1  winner presented.
- irq_lvl  out  LW  presented level index.
- irq_chan  out  CW  presented channel index.
- irq_ack  in  1  CPU accepts the presented interrupt.
- in_service  out  1  an interrupt is being serviced.
- eoi  in  1  end-of-interrupt strobe.
- spurious_eoi  out  1  one-cycle pulse: eoi received while not in service.
- lost_edge  out  1  one-cycle pulse: edge arrived on an already-pending bit (EDGE_MODE=1 only).

Behaviour:
- Reset: all outputs 0, pend = 0, req_q = 0, state = IDLE. Reset mid-operation aborts any presentation or service without issuing an ack.
- Capture, level mode: pend[i] <= req[i] & chan_en[c] every cycle. Acknowledging a bit does not clear it while the request stays asserted.
- Capture, edge mode: rise = req & ~req_q. The pend bit is set on rise & chan_en and cleared on ack of that bit. If set and clear hit the same bit in the same cycle, set wins. A rise on a bit already at 1 pulses lost_edge.
- Disabling a channel clears its pend bits in both modes on the next edge.
- lvl_pend is registered from pend, so it trails pend by one cycle.
- Arbitration (combinational on pend):
  - Winning level is the lowest l with any pend bit.
  - Winning channel is the lowest c within that level.
- FSM states and transitions:
  - IDLE: if any pend bit is set, latch the winner into irq_lvl/irq_chan and go to PRESENT.
  - PRESENT: irq_valid = 1. irq_lvl/irq_chan stay frozen until ack, even if a higher-priority source arrives or the request is withdrawn. On irq_ack: clear the pend bit (edge mode), set in_service, go to SERVICE.
  - SERVICE: irq_valid = 0, in_service = 1, irq_lvl/irq_chan keep the serviced source. New requests are captured but not presented. On eoi: in_service = 0, go to IDLE.
- Re-presentation from IDLE takes effect the cycle after EOI, so there is at least one idle cycle between services.
- eoi in IDLE or PRESENT pulses spurious_eoi and causes no state change.
- irq_ack outside PRESENT is ignored.
- Latency: request sampled high at edge k → pend = 1 after edge k → irq_valid = 1 after edge k+1 (two cycles). Ack sampled at edge m → in_service = 1 after edge m.
- No arithmetic beyond index encoding. Indices are zero-extended to CW/LW.

Decomposition:
- Package pic_seq_pkg holds:
  - typedef enum {IDLE, PRESENT, SERVICE} pic_state_t;
  - function clog2_min1 (used for LW/CW);
  - localparam DEFAULT_N_CHAN = 9, DEFAULT_N_LVL = 3.
- One sub-module, pic_prio_enc #(W): lowest-index-wins priority encoder (outputs any, idx). Instantiated once per level and once across the level-any vector.

Test Plan:
- Reset/idle: hold rst_n = 0 with random req → all outputs 0. Release with req = 0 → irq_valid stays 0 for 10 cycles.
- Priority, level mode, all chan_en = 1:
  - Assert level-1 ch4 and level-0 ch7 together → irq_valid after 2 cycles with lvl = 0, chan = 7.
  - Ack, then eoi → lvl = 1, chan = 4 presented.
- Stability: in PRESENT with lvl = 2, chan = 3, raise level-0 ch0 before ack → presented values unchanged until ack. After eoi, lvl = 0, chan = 0 is presented.
- Edge mode, same-bit collision: pulse level-0 ch2 twice before ack → one lost_edge pulse. Ack on the same cycle as a new rise on ch2 → pend stays 1 and ch2 is re-presented after eoi.
- Masking: chan_en[5] = 0 with req on ch5 at every level → never presented and lvl_pend = 0. Set chan_en[5] = 1 → lvl = 0, chan = 5 after 2 cycles.
- Errors and async reset: eoi in IDLE → spurious_eoi for exactly 1 cycle. Assert rst_n low during SERVICE → in_service drops immediately, without waiting for a clock edge.
